gcd_stream_driver: RTL and testbench

- Synthesizable on-chip traffic source/sink for the gcd unit; replaces the simulation-only stimulus path for silicon bring-up and power measurement.
- Holds a small programmable vector table of (A, B, expected) entries.
- Plays each entry into the gcd operand val/rdy interface and accepts the result on the result val/rdy interface.
- Compares each result, accumulates pass/fail counts and guards each vector with a timeout.

---
 rtl/gcd_test_pkg.sv | 24 ++
 rtl/gcd_vec_table.sv | 38 +++
 rtl/gcd_stream_driver.sv | 207 ++++++++++++++++++++
 tb/tb_gcd_stream_driver.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_test_pkg.sv
// Shared definitions for the gcd stream driver: FSM states, default sizes and
// the constants of the backpressure LFSR.
package gcd_test_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StDone
  } state_e;

  localparam int unsigned DefaultW             = 16;
  localparam int unsigned DefaultDepth         = 8;
  localparam int unsigned DefaultTimeoutCycles = 1000;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
  endfunction

endpackage

// File: rtl/gcd_vec_table.sv
// DEPTH x (A, B, expected) vector register file: one synchronous write port,
// one combinational read port. Contents are deliberately not reset.
module gcd_vec_table
  import gcd_test_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_a,
  input  logic [W-1:0]             wr_b,
  input  logic [W-1:0]             wr_exp,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_a,
  output logic [W-1:0]             rd_b,
  output logic [W-1:0]             rd_exp
);

  logic [W-1:0] a_q   [DEPTH];
  logic [W-1:0] b_q   [DEPTH];
  logic [W-1:0] exp_q [DEPTH];

  // Table write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_q[wr_addr]   <= wr_a;
      b_q[wr_addr]   <= wr_b;
      exp_q[wr_addr] <= wr_exp;
    end
  end

  assign rd_a   = a_q[rd_addr];
  assign rd_b   = b_q[rd_addr];
  assign rd_exp = exp_q[rd_addr];

endmodule

// File: rtl/gcd_stream_driver.sv
// On-chip traffic source/sink for the gcd unit. Plays a programmable vector
// table into the operand val/rdy port, checks each result and counts
// pass/fail, with a per-vector timeout.
// Optional: define GCD_STREAM_DRIVER_BACKPRESSURE_EN to throttle result_rdy
// with a 16-bit LFSR while waiting for a result.
module gcd_stream_driver
  import gcd_test_pkg::*;
#(
  parameter int unsigned W              = DefaultW,
  parameter int unsigned DEPTH          = DefaultDepth,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tbl_wr_en,
  input  logic [$clog2(DEPTH)-1:0] tbl_wr_addr,
  input  logic [W-1:0]             tbl_wr_a,
  input  logic [W-1:0]             tbl_wr_b,
  input  logic [W-1:0]             tbl_wr_exp,
  input  logic [$clog2(DEPTH):0]   num_vectors,
  input  logic                     start,
  output logic [W-1:0]             operands_bits_A,
  output logic [W-1:0]             operands_bits_B,
  output logic                     operands_val,
  input  logic                     operands_rdy,
  input  logic [W-1:0]             result_bits_data,
  input  logic                     result_val,
  output logic                     result_rdy,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   pass_count,
  output logic [$clog2(DEPTH):0]   fail_count,
  output logic [$clog2(DEPTH)-1:0] first_fail_idx,
  output logic                     timeout
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] n_q;
  logic [TW-1:0] timer_q;
  logic [W-1:0]  exp_q;

  logic          idle_like;
  logic          tbl_we;
  logic [IW-1:0] rd_addr;
  logic [W-1:0]  rd_a, rd_b, rd_exp;
  logic          fwd;
  logic [W-1:0]  ld_a, ld_b, ld_exp;
  logic [CW-1:0] n_clamped;
  logic          op_hs, res_hs, last_vec;
  logic          wait_rdy;

  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign tbl_we    = tbl_wr_en && idle_like;

  // The read port always points at the entry that will be loaded into the
  // operand registers on the next SEND entry: 0 on start, idx+1 after a result.
  assign rd_addr = (state_q == StWait) ? idx_q + IW'(1) : '0;

  // A write landing in the same cycle as start must be seen by the run.
  assign fwd    = tbl_we && (tbl_wr_addr == rd_addr);
  assign ld_a   = fwd ? tbl_wr_a   : rd_a;
  assign ld_b   = fwd ? tbl_wr_b   : rd_b;
  assign ld_exp = fwd ? tbl_wr_exp : rd_exp;

  assign n_clamped = (num_vectors > DepthC) ? DepthC : num_vectors;
  assign op_hs     = operands_val && operands_rdy;
  assign res_hs    = result_val && result_rdy;
  assign last_vec  = ({1'b0, idx_q} == (n_q - CW'(1)));

  gcd_vec_table #(
    .W    (W),
    .DEPTH(DEPTH)
  ) u_table (
    .clk    (clk),
    .wr_en  (tbl_we),
    .wr_addr(tbl_wr_addr),
    .wr_a   (tbl_wr_a),
    .wr_b   (tbl_wr_b),
    .wr_exp (tbl_wr_exp),
    .rd_addr(rd_addr),
    .rd_a   (rd_a),
    .rd_b   (rd_b),
    .rd_exp (rd_exp)
  );

`ifdef GCD_STREAM_DRIVER_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = lfsr_step(lfsr_q);
  // result_rdy is registered, so it takes the bit the LFSR will hold next cycle.
  assign wait_rdy = lfsr_d[0];

  // Free-running backpressure pattern generator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign wait_rdy = 1'b1;
`endif

  // Run sequencer: state, counters, timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      n_q             <= '0;
      timer_q         <= '0;
      exp_q           <= '0;
      operands_bits_A <= '0;
      operands_bits_B <= '0;
      operands_val    <= 1'b0;
      result_rdy      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass_count      <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      timeout         <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          // An empty run parks here with busy=1 for one cycle, so done rises late.
          if (state_q == StDone) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          if (start) begin
            done           <= 1'b0;
            busy           <= 1'b1;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            timeout        <= 1'b0;
            idx_q          <= '0;
            n_q            <= n_clamped;
            if (n_clamped == '0) begin
              state_q <= StDone;
            end else begin
              state_q         <= StSend;
              operands_val    <= 1'b1;
              operands_bits_A <= ld_a;
              operands_bits_B <= ld_b;
              exp_q           <= ld_exp;
            end
          end
        end
        StSend: begin
          if (op_hs) begin
            operands_val <= 1'b0;
            timer_q      <= '0;
            result_rdy   <= wait_rdy;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (res_hs) begin
            if (result_bits_data == exp_q) begin
              pass_count <= pass_count + CW'(1);
            end else begin
              fail_count <= fail_count + CW'(1);
              if (fail_count == '0) begin
                first_fail_idx <= idx_q;
              end
            end
            if (last_vec) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              idx_q           <= idx_q + IW'(1);
              state_q         <= StSend;
              operands_val    <= 1'b1;
              operands_bits_A <= ld_a;
              operands_bits_B <= ld_b;
              exp_q           <= ld_exp;
            end
          end else if (timer_q == TimerMax) begin
            // Outstanding vector is abandoned: neither pass nor fail.
            timeout <= 1'b1;
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            timer_q    <= timer_q + TW'(1);
            result_rdy <= wait_rdy;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stream_driver.sv
// Directed bench for gcd_stream_driver with a behavioural gcd responder.
module tb_gcd_stream_driver;

  localparam int unsigned W              = 16;
  localparam int unsigned DEPTH          = 8;
  localparam int unsigned TIMEOUT_CYCLES = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        tbl_wr_en;
  logic [2:0]  tbl_wr_addr;
  logic [15:0] tbl_wr_a, tbl_wr_b, tbl_wr_exp;
  logic [3:0]  num_vectors;
  logic        start;
  logic [15:0] operands_bits_A, operands_bits_B;
  logic        operands_val, operands_rdy;
  logic [15:0] result_bits_data;
  logic        result_val, result_rdy;
  logic        busy, done;
  logic [3:0]  pass_count, fail_count;
  logic [2:0]  first_fail_idx;
  logic        timeout;

  always #5 clk = ~clk;

  gcd_stream_driver #(
    .W             (W),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tbl_wr_en       (tbl_wr_en),
    .tbl_wr_addr     (tbl_wr_addr),
    .tbl_wr_a        (tbl_wr_a),
    .tbl_wr_b        (tbl_wr_b),
    .tbl_wr_exp      (tbl_wr_exp),
    .num_vectors     (num_vectors),
    .start           (start),
    .operands_bits_A (operands_bits_A),
    .operands_bits_B (operands_bits_B),
    .operands_val    (operands_val),
    .operands_rdy    (operands_rdy),
    .result_bits_data(result_bits_data),
    .result_val      (result_val),
    .result_rdy      (result_rdy),
    .busy            (busy),
    .done            (done),
    .pass_count      (pass_count),
    .fail_count      (fail_count),
    .first_fail_idx  (first_fail_idx),
    .timeout         (timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int op_val_cycles = 0;
  always @(negedge clk) if (operands_val) op_val_cycles <= op_val_cycles + 1;

  // Responder controls and observations.
  int          rdy_stall     = 0;
  int          resp_delay    = 2;
  bit          never_respond = 1'b0;
  bit          abort         = 1'b0;
  int          hs_count      = 0;
  int unsigned hs_cyc        = 0;
  logic [15:0] cap_a         = '0;

  // Behavioural gcd: accept operands after rdy_stall cycles, answer after resp_delay.
  initial begin : gcd_model
    int stall, stable;
    logic [15:0] a0, b0, g;
    operands_rdy     = 1'b0;
    result_val       = 1'b0;
    result_bits_data = '0;
    forever begin
      stall  = 0;
      stable = 0;
      a0     = '0;
      b0     = '0;
      forever begin
        @(negedge clk);
        if (operands_val) begin
          if (stall == 0) begin
            a0 = operands_bits_A;
            b0 = operands_bits_B;
          end
          if (stall < rdy_stall) begin
            if (operands_bits_A == a0 && operands_bits_B == b0) stable++;
            stall++;
          end else begin
            operands_rdy = 1'b1;
            break;
          end
        end
      end
      if (rdy_stall > 0) begin
        check("stall_hold_ab", stable, rdy_stall);
        check("stall_final_a", operands_bits_A, a0);
        check("stall_final_b", operands_bits_B, b0);
      end
      @(posedge clk);
      @(negedge clk);
      operands_rdy = 1'b0;
      hs_count++;
      hs_cyc = cyc;
      cap_a  = a0;
      g      = gcd_ref(a0, b0);
      if (!never_respond) begin
        repeat (resp_delay) @(negedge clk);
        result_bits_data = g;
        result_val       = 1'b1;
        for (int i = 0; i < 5000; i++) begin
          if (abort) break;
          if (result_rdy) begin
            @(posedge clk);
            @(negedge clk);
            break;
          end
          @(negedge clk);
        end
        result_val = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e;
  } vec_t;

  typedef struct {
    int nv;
    int bad0;
    int bad1;
    int exp_pass;
    int exp_fail;
    int exp_ffi;
    int exp_hs;
  } run_t;

  vec_t vecs[8];
  run_t runs[4];

  task automatic write_entry(input int idx, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] e);
    @(negedge clk);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 3'(idx);
    tbl_wr_a    = a;
    tbl_wr_b    = b;
    tbl_wr_exp  = e;
    @(negedge clk);
    tbl_wr_en = 1'b0;
  endtask

  // Entries listed in bad0/bad1 get a wrong expected value (correct + 1).
  task automatic load_table(input int bad0, input int bad1);
    for (int i = 0; i < 8; i++) begin
      if (i == bad0 || i == bad1) write_entry(i, vecs[i].a, vecs[i].b, vecs[i].e + 16'd1);
      else write_entry(i, vecs[i].a, vecs[i].b, vecs[i].e);
    end
  endtask

  task automatic pulse_start(input int nv);
    @(negedge clk);
    num_vectors = 4'(nv);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int unsigned dcyc);
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done_seen", done, 1);
    dcyc = cyc;
  endtask

  initial begin : main
    int unsigned dc;
    int hs0, ov0;
    reset       = 1'b0;
    tbl_wr_en   = 1'b0;
    tbl_wr_addr = '0;
    tbl_wr_a    = '0;
    tbl_wr_b    = '0;
    tbl_wr_exp  = '0;
    num_vectors = '0;
    start       = 1'b0;

    vecs[0] = '{16'd27,  16'd15,  16'd3};
    vecs[1] = '{16'd21,  16'd49,  16'd7};
    vecs[2] = '{16'd25,  16'd30,  16'd5};
    vecs[3] = '{16'd19,  16'd27,  16'd1};
    vecs[4] = '{16'd40,  16'd40,  16'd40};
    vecs[5] = '{16'd250, 16'd190, 16'd10};
    vecs[6] = '{16'd5,   16'd250, 16'd5};
    vecs[7] = '{16'd12,  16'd18,  16'd6};

    //           nv bad0 bad1 pass fail ffi hs
    runs[0] = '{ 7,  -1,  -1,  7,   0,   0,  7};
    runs[1] = '{ 7,   2,  -1,  6,   1,   2,  7};
    runs[2] = '{12,  -1,  -1,  8,   0,   0,  8};
    runs[3] = '{ 5,   1,   4,  3,   2,   1,  5};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_ffi", first_fail_idx, 0);
    check("rst_timeout", timeout, 0);
    check("rst_op_val", operands_val, 0);
    check("rst_res_rdy", result_rdy, 0);
    check("rst_a", operands_bits_A, 0);
    check("rst_b", operands_bits_B, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      load_table(runs[r].bad0, runs[r].bad1);
      hs0 = hs_count;
      pulse_start(runs[r].nv);
      wait_done(dc);
      check($sformatf("run%0d_pass", r), pass_count, runs[r].exp_pass);
      check($sformatf("run%0d_fail", r), fail_count, runs[r].exp_fail);
      check($sformatf("run%0d_ffi", r), first_fail_idx, runs[r].exp_ffi);
      check($sformatf("run%0d_timeout", r), timeout, 0);
      check($sformatf("run%0d_busy", r), busy, 0);
      check($sformatf("run%0d_hs", r), hs_count - hs0, runs[r].exp_hs);
    end
    load_table(-1, -1);

    // Table write and start in the same cycle: the run uses the new entry 0.
    @(negedge clk);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 3'd0;
    tbl_wr_a    = 16'd48;
    tbl_wr_b    = 16'd36;
    tbl_wr_exp  = 16'd12;
    num_vectors = 4'd1;
    start       = 1'b1;
    @(negedge clk);
    tbl_wr_en = 1'b0;
    start     = 1'b0;
    wait_done(dc);
    check("wrstart_pass", pass_count, 1);
    check("wrstart_fail", fail_count, 0);
    check("wrstart_a", cap_a, 48);
    write_entry(0, vecs[0].a, vecs[0].b, vecs[0].e);

    // Empty run: done drops, then rises two cycles after start, no operands.
    @(negedge clk);
    ov0 = op_val_cycles;
    pulse_start(0);
    check("n0_done_low", done, 0);
    check("n0_busy_high", busy, 1);
    @(negedge clk);
    check("n0_done_high", done, 1);
    check("n0_busy_low", busy, 0);
    @(negedge clk);
    check("n0_no_op_val", op_val_cycles - ov0, 0);

    // Operand stall, plus a table write attempted mid-run that must be ignored.
    rdy_stall = 20;
    hs0 = hs_count;
    pulse_start(2);
    repeat (3) @(negedge clk);
    write_entry(1, 16'd21, 16'd49, 16'd999);
    wait_done(dc);
    check("stall_pass", pass_count, 2);
    check("stall_fail", fail_count, 0);
    check("stall_hs", hs_count - hs0, 2);
    rdy_stall = 0;

    // No result ever arrives.
    never_respond = 1'b1;
    pulse_start(1);
    wait_done(dc);
    check("to_flag", timeout, 1);
    check("to_pass", pass_count, 0);
    check("to_fail", fail_count, 0);
    check("to_latency", dc - hs_cyc, 50);
    check("to_busy", busy, 0);
    never_respond = 1'b0;

    // Reset while waiting on vector 3's result.
    resp_delay = 10;
    hs0 = hs_count;
    pulse_start(7);
    for (int i = 0; i < 2000; i++) begin
      if (hs_count - hs0 >= 4) break;
      @(negedge clk);
    end
    check("mid_hs_reached", hs_count - hs0, 4);
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass_count, 0);
    check("mid_rst_fail", fail_count, 0);
    check("mid_rst_op_val", operands_val, 0);
    check("mid_rst_res_rdy", result_rdy, 0);
    check("mid_rst_timeout", timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
